// File: rtl/mc_controller.sv
// ---------------------------------------------------------------
// mc_controller : multicycle RV32 subset control FSM (Moore), rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mc_controller #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       adrsrc,
  output logic       illegal,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  logic       ready;
  logic [3:0] next_state;
  logic [1:0] aluop;
  logic       is_lw, is_sw, is_r, is_i, is_beq, is_jal;

  // Without wait support the memory is treated as always completing.
  assign ready = mem_ready | (MEM_WAIT == 0);

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_beq = (op == OP_BEQ);
  assign is_jal = (op == OP_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (ready) next_state = DECODE;
      DECODE: begin
        if (is_lw || is_sw) next_state = MEMADR;
        else if (is_r)      next_state = EXECR;
        else if (is_i)      next_state = EXECI;
        else if (is_beq)    next_state = BEQ;
        else if (is_jal)    next_state = JAL;
        else                next_state = TRAP;
      end
      MEMADR:   next_state = is_sw ? MEMWRITE : MEMREAD;
      MEMREAD:  if (ready) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (ready) next_state = FETCH;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    adrsrc    = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = ALU_ADD;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = ready;
        pcwrite   = ready;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
      end
      EXECR: begin
        alusrca = 2'b10;
        aluop   = ALU_FUNCT;
      end
      EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALU_FUNCT;
      end
      ALUWB:    regwrite = 1'b1;
      BEQ: begin
        alusrca = 2'b10;
        aluop   = ALU_SUB;
        pcwrite = zero;
      end
      JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      TRAP:     illegal = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    if (is_sw)       immsrc = 2'b01;
    else if (is_beq) immsrc = 2'b10;
    else if (is_jal) immsrc = 2'b11;
  end

  // Subtract only for R-type funct3=000 with funct7[5]; I-type addi ignores instr[30].
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALU_SUB: alucontrol = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------
// tb_mc_controller : self-checking bench for mc_controller, rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       mem_req, memwrite, irwrite, pcwrite, regwrite, adrsrc, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       n_mem_req, n_memwrite, n_irwrite, n_pcwrite, n_regwrite, n_adrsrc, n_illegal;
  logic [1:0] n_resultsrc, n_alusrca, n_alusrcb, n_immsrc;
  logic [2:0] n_alucontrol;
  logic [3:0] n_state;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .adrsrc(adrsrc),
    .illegal(illegal), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .state(state)
  );

  mc_controller #(.MEM_WAIT(0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(1'b0), .mem_req(n_mem_req), .memwrite(n_memwrite),
    .irwrite(n_irwrite), .pcwrite(n_pcwrite), .regwrite(n_regwrite), .adrsrc(n_adrsrc),
    .illegal(n_illegal), .resultsrc(n_resultsrc), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .immsrc(n_immsrc), .alucontrol(n_alucontrol), .state(n_state)
  );

  always #5 clk = ~clk;

  logic [21:0] act_bus;
  assign act_bus = {mem_req, memwrite, irwrite, pcwrite, regwrite, adrsrc, illegal,
                    resultsrc, alusrca, alusrcb, immsrc, alucontrol, state};

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int pend[$];

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] st;
    logic [2:0] alu;
    logic       pcw;
  } vec_t;
  vec_t tbl[14];

  function automatic logic is_legal(logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Output table per state number, straight from the per-state rules.
  function automatic logic [21:0] expect_out(int st, logic [6:0] o, logic [2:0] f3,
                                             logic f7, logic z, logic rdy);
    logic mreq = 0, mw = 0, ir = 0, pcw = 0, rw = 0, adr = 0, ill = 0;
    logic [1:0] rs = 0, a = 0, b = 0, imm = 0;
    logic [2:0] alu = 0;
    logic [3:0] s4;
    int kind = 0;  // 0 add, 1 sub, 2 funct
    s4 = st[3:0];
    case (st)
      0:  begin mreq = 1; b = 2; rs = 2; ir = rdy; pcw = rdy; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mreq = 1; mw = 1; adr = 1; end
      6:  begin a = 2; kind = 2; end
      7:  begin a = 2; b = 1; kind = 2; end
      8:  rw = 1;
      9:  begin a = 2; kind = 1; pcw = z; end
      10: begin a = 1; b = 2; pcw = 1; end
      11: ill = 1;
      default: ;
    endcase
    if (o == 7'b0100011) imm = 1;
    else if (o == 7'b1100011) imm = 2;
    else if (o == 7'b1101111) imm = 3;
    if (kind == 1) alu = 3'b001;
    else if (kind == 2) begin
      if (f3 == 3'b000) alu = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) alu = 3'b101;
      else if (f3 == 3'b110) alu = 3'b011;
      else if (f3 == 3'b111) alu = 3'b010;
    end
    return {mreq, mw, ir, pcw, rw, adr, ill, rs, a, b, imm, alu, s4};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction-level path: the states visited after FETCH for a given opcode.
  task automatic load_path(input logic [6:0] o);
    pend.delete();
    pend.push_back(1);
    case (o)
      7'b0000011: begin pend.push_back(2); pend.push_back(3); pend.push_back(4); end
      7'b0100011: begin pend.push_back(2); pend.push_back(5); end
      7'b0110011: begin pend.push_back(6); pend.push_back(8); end
      7'b0010011: begin pend.push_back(7); pend.push_back(8); end
      7'b1100011: pend.push_back(9);
      7'b1101111: begin pend.push_back(10); pend.push_back(8); end
      default:    pend.push_back(11);
    endcase
  endtask

  task automatic model_advance();
    if (cur == 11) return;
    if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) return;
    if (cur == 0) load_path(op);
    if (pend.size() == 0) cur = 0;
    else cur = pend.pop_front();
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances one clock.
  task automatic cycle_model(input string name);
    @(negedge clk);
    check(name, act_bus, expect_out(cur, op, funct3, funct7b5, zero, mem_ready));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async_state", state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = 0;
    pend.delete();
  endtask

  int lw_seq[6];
  int cnt;

  initial begin
    lw_seq = '{0, 1, 2, 3, 4, 0};
    tbl[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'd6,  3'b001, 1'b0};
    tbl[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4'd6,  3'b000, 1'b0};
    tbl[2]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4'd6,  3'b101, 1'b0};
    tbl[3]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4'd6,  3'b011, 1'b0};
    tbl[4]  = '{7'b0110011, 3'b111, 1'b1, 1'b0, 4'd6,  3'b010, 1'b0};
    tbl[5]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 4'd6,  3'b000, 1'b0};
    tbl[6]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'd7,  3'b000, 1'b0};
    tbl[7]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4'd7,  3'b101, 1'b0};
    tbl[8]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'd9,  3'b001, 1'b1};
    tbl[9]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 4'd9,  3'b001, 1'b0};
    tbl[10] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'd10, 3'b000, 1'b1};
    tbl[11] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'd2,  3'b000, 1'b0};
    tbl[12] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4'd2,  3'b000, 1'b0};
    tbl[13] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 4'd11, 3'b000, 1'b0};

    #2;
    check("reset_state", state, 0);
    check("reset_fetch_outputs", act_bus, expect_out(0, op, funct3, funct7b5, zero, mem_ready));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: third-cycle state, alucontrol and pcwrite per instruction class.
    for (int i = 0; i < 14; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = tbl[i].z;
      mem_ready = 1'b1;
      do_reset();
      cycle_model("tbl_fetch");
      cycle_model("tbl_decode");
      @(negedge clk);
      check($sformatf("tbl%0d_state", i), state, tbl[i].st);
      check($sformatf("tbl%0d_alucontrol", i), alucontrol, tbl[i].alu);
      check($sformatf("tbl%0d_pcwrite", i), pcwrite, tbl[i].pcw);
    end

    // lw with memory always ready.
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("lw_state%0d", k), state, lw_seq[k]);
      check($sformatf("lw_regwrite%0d", k), regwrite, (k == 4));
      if (k < 5) check($sformatf("lw_irwrite%0d", k), irwrite, (k == 0));
      @(posedge clk);
      #1;
    end

    // sw stalled three cycles in MEMWRITE.
    op = 7'b0100011; mem_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) cycle_model("sw_pre");
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      if (memwrite) cnt++;
      check("sw_memwrite_state", state, 5);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("sw_memwrite_cycles", cnt, 4);
    check("sw_back_to_fetch", state, 0);
    check("sw_memwrite_dropped", memwrite, 0);
    @(posedge clk);
    #1;

    // Reset while a store is pending: abandon it without waiting for a clock.
    mem_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) cycle_model("swrst_pre");
    mem_ready = 1'b0;
    @(negedge clk);
    check("swrst_memwrite_before", memwrite, 1);
    rst_n = 1'b0;
    #1;
    check("swrst_memwrite_drop", memwrite, 0);
    check("swrst_state", state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = 0;
    pend.delete();

    // Illegal opcode traps and stays trapped.
    op = 7'b1111111; mem_ready = 1'b1;
    do_reset();
    cycle_model("ill_fetch");
    cycle_model("ill_decode");
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (illegal && !irwrite && !pcwrite && !memwrite && state == 4'd11) cnt++;
      @(posedge clk);
      #1;
    end
    check("ill_sticky_cycles", cnt, 12);
    do_reset();
    @(negedge clk);
    check("ill_after_reset", act_bus, expect_out(0, op, funct3, funct7b5, zero, mem_ready));

    // MEM_WAIT=0 instance ignores its tied-low mem_ready.
    op = 7'b0000011; mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("nowait_state%0d", k), n_state, lw_seq[k]);
      @(posedge clk);
      #1;
    end

    // Random instruction stream against the path model.
    mem_ready = 1'b1;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cur == 11) begin
        cnt++;
        if (cnt > 3) begin
          cnt = 0;
          do_reset();
        end
      end
      if (cur == 0) begin
        case ($urandom_range(0, 6))
          0: op = 7'b0000011;
          1: op = 7'b0100011;
          2: op = 7'b0110011;
          3: op = 7'b0010011;
          4: op = 7'b1100011;
          5: op = 7'b1101111;
          default: begin
            op = 7'($urandom);
            while (is_legal(op)) op = 7'($urandom);
          end
        endcase
        funct3 = 3'($urandom);
        funct7b5 = 1'($urandom);
      end
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = honour mem_ready; 0 = mem_ready internally forced to 1.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port op  input  7  instruction opcode, instr[6:0].
REQ-005 SHALL have port funct3  input  3  instr[14:12].
REQ-006 SHALL have port funct7b5  input  1  instr[30].
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-009 SHALL have outputs mem_req 1, memwrite 1, irwrite 1, pcwrite 1, regwrite 1, adrsrc 1, illegal 1, resultsrc 2, alusrca 2, alusrcb 2, immsrc 2, alucontrol 3, state 4 (debug); all are outputs.
REQ-010 SHALL use one clock domain only; reset is asynchronous and active-low.

Function
REQ-011 SHALL implement a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. The state output SHALL carry the encoding.
REQ-012 SHALL decode opcodes as: lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111. Any other opcode is illegal.
REQ-013 FETCH: mem_req=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, adrsrc=0. irwrite=pcwrite=mem_ready. On mem_ready go to DECODE, else hold.
REQ-014 DECODE: alusrca=01, alusrcb=01, aluop=add. Next state: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, beq->BEQ, jal->JAL, illegal->TRAP.
REQ-015 MEMADR: alusrca=10, alusrcb=01, aluop=add. lw->MEMREAD, sw->MEMWRITE.
REQ-016 MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. On mem_ready go to MEMWB, else hold.
REQ-017 MEMWB: resultsrc=01, regwrite=1, then FETCH.
REQ-018 MEMWRITE: mem_req=1, memwrite=1, adrsrc=1, resultsrc=00. Both held for every cycle in the state. On mem_ready go to FETCH.
REQ-019 EXECR: alusrca=10, alusrcb=00, aluop=funct, then ALUWB.
REQ-020 EXECI: alusrca=10, alusrcb=01, aluop=funct, then ALUWB.
REQ-021 ALUWB: resultsrc=00, regwrite=1, then FETCH.
REQ-022 BEQ: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00, pcwrite=zero, then FETCH.
REQ-023 JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcwrite=1, then ALUWB.
REQ-024 TRAP: illegal=1, all enables 0. TRAP SHALL be sticky until reset.
REQ-025 Any output not listed for a state SHALL be 0.
REQ-026 immsrc SHALL be combinational from op in every state: sw=01, beq=10, jal=11, all others=00.
REQ-027 alucontrol SHALL be derived as follows:
- aluop add -> 000; aluop sub -> 001.
- aluop funct, funct3=000: 001 if op[5]&funct7b5, else 000.
- aluop funct, funct3=010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-028 irwrite, pcwrite and memwrite SHALL never be asserted in the same cycle as illegal.
REQ-029 There SHALL be no timeout; a hold on mem_ready stalls the FSM indefinitely.

Reset
REQ-030 rst_n=0 SHALL force state=FETCH immediately, without waiting for a clock edge. Outputs follow as the FETCH decode with mem_ready gating.
REQ-031 Reset asserted mid-instruction (including MEMWRITE with memwrite=1) SHALL abandon the instruction. memwrite SHALL drop in the same cycle.
REQ-032 The first transition after rst_n deasserts SHALL occur on the first rising clk edge.

Verification
REQ-033 lw with mem_ready=1 always -> states 0,1,2,3,4,0; regwrite=1 only in MEMWB; irwrite=1 in cycle 0 only.
REQ-034 sw, mem_ready low for 3 cycles in MEMWRITE -> memwrite=1 for 4 consecutive cycles, then FETCH.
REQ-035 beq: zero=1 -> pcwrite=1 in BEQ, alucontrol=001; zero=0 -> pcwrite=0.
REQ-036 R-type sub (funct3=000, funct7b5=1) -> alucontrol=001 in EXECR. I-type addi with funct7b5=1 -> alucontrol=000.
REQ-037 op=1111111 -> DECODE->TRAP, illegal=1 held for 10+ cycles; rst_n pulse -> FETCH.
REQ-038 MEM_WAIT=0 with mem_ready tied 0 -> lw completes in 5 cycles.
